// File: rtl/gate_vector_serializer_pkg.sv
// Shared types and constants for the gate-vector serializer: FSM states,
// default vector width and the bit position of each gate in the vector.
package gate_ser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } ser_state_e;

  localparam int GATE_W = 7;

  localparam int AND_B  = 0;
  localparam int NAND_B = 1;
  localparam int OR_B   = 2;
  localparam int NOR_B  = 3;
  localparam int XOR_B  = 4;
  localparam int XNOR_B = 5;
  localparam int NOT_B  = 6;

endpackage

// File: rtl/gate_vector_serializer_bit_counter.sv
// Data-beat index counter: cleared on capture, advanced per accepted data
// beat, saturating at W-1 where it raises the terminal flag.
module ser_bit_counter #(
  parameter int W  = 7,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [IW-1:0] o_idx,
  output logic          o_term
);

  logic [IW-1:0] r_idx;

  assign o_idx  = r_idx;
  assign o_term = (r_idx == IW'(W - 1));

  // Clear wins over enable so a capture in the finishing cycle restarts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_en && !o_term) begin
      r_idx <= r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/gate_vector_serializer.sv
// Serializes a captured gate result vector LSB first with start/last
// markers and an optional even-parity trailer beat.
module gate_vector_serializer
  import gate_ser_pkg::*;
#(
  parameter int W         = GATE_W,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_bit,
  output logic         out_sof,
  output logic         out_last,
  output logic         busy,
  output logic [7:0]   frame_cnt
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  ser_state_e    r_state;
  ser_state_e    w_state_nxt;
  logic [W-1:0]  r_sh;
  logic          r_par;
  logic [7:0]    r_frame_cnt;

  logic [IW-1:0] w_idx;
  logic          w_term;
  logic          w_out_valid;
  logic          w_out_last;
  logic          w_beat;
  logic          w_data_beat;
  logic          w_finish;
  logic          w_in_ready;
  logic          w_cap;

  assign w_out_valid = (r_state != IDLE);
  assign w_out_last  = (r_state == PAR) || ((r_state == DATA) && w_term && !PARITY_EN);
  assign w_beat      = w_out_valid && out_ready;
  assign w_data_beat = w_beat && (r_state == DATA);
  assign w_finish    = w_beat && w_out_last;
  // Accepting in the finishing cycle lets frames run back to back.
  assign w_in_ready  = (r_state == IDLE) || w_finish;
  assign w_cap       = in_valid && w_in_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_last  = w_out_last;
  assign out_sof   = (r_state == DATA) && (w_idx == '0);
  assign out_bit   = (r_state == DATA) ? r_sh[0] :
                     (r_state == PAR)  ? r_par   : 1'b0;
  assign busy      = w_out_valid;
  assign frame_cnt = r_frame_cnt;

  ser_bit_counter #(
    .W  (W),
    .IW (IW)
  ) u_bit_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_cap),
    .i_en   (w_data_beat),
    .o_idx  (w_idx),
    .o_term (w_term)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_cap) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_beat && w_term) begin
          if (PARITY_EN) w_state_nxt = PAR;
          else           w_state_nxt = w_cap ? DATA : IDLE;
        end
      end
      PAR: begin
        if (w_beat) w_state_nxt = w_cap ? DATA : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_finish) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  // Payload registers carry no reset; outputs are gated by state instead.
  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_sh  <= in_vec;
      r_par <= ^in_vec;
    end else if (w_data_beat) begin
      r_sh  <= r_sh >> 1;
    end
  end

endmodule

// File: tb/tb_gate_vector_serializer.sv
// Scoreboard bench for gate_vector_serializer: one instance with parity,
// one without, directed vectors with hand-computed beats and parities.
module tb_gate_vector_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid, out_ready;
  logic [6:0] in_vec;
  logic       in_ready, out_valid, out_bit, out_sof, out_last, busy;
  logic [7:0] frame_cnt;

  logic       z_in_valid, z_out_ready;
  logic [6:0] z_in_vec;
  logic       z_in_ready, z_out_valid, z_out_bit, z_out_sof, z_out_last, z_busy;
  logic [7:0] z_frame_cnt;

  gate_vector_serializer #(.W(7), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_sof(out_sof), .out_last(out_last),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  gate_vector_serializer #(.W(7), .PARITY_EN(1'b0)) dut_np (
    .clk(clk), .rst_n(rst_n), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .in_vec(z_in_vec), .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_bit(z_out_bit), .out_sof(z_out_sof), .out_last(z_out_last),
    .busy(z_busy), .frame_cnt(z_frame_cnt)
  );

  typedef struct packed {logic b; logic sof; logic last;} beat_t;
  beat_t q1[$];
  beat_t q0[$];
  beat_t e1, e0, prev1;
  logic  stall1 = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Beats LSB first; parity value is supplied by hand per vector.
  task automatic push_frame(input logic [6:0] v, input logic par, input bit pe, input bit to_np);
    beat_t bt;
    for (int i = 0; i < 7; i++) begin
      bt = '{v[i], (i == 0), ((i == 6) && !pe)};
      if (to_np) q0.push_back(bt); else q1.push_back(bt);
    end
    if (pe) begin
      bt = '{par, 1'b0, 1'b1};
      q1.push_back(bt);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall1 = 1'b0;
    end else begin
      if (stall1) check("stall_hold", {out_valid, out_bit, out_sof, out_last}, {1'b1, prev1});
      if (out_valid && !(out_ready && out_last)) check("in_ready_mid_frame", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q1.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          e1 = q1.pop_front();
          check("beat", {out_bit, out_sof, out_last}, e1);
        end
      end
      stall1 = out_valid && !out_ready;
      prev1  = '{out_bit, out_sof, out_last};
    end
  end

  always @(negedge clk) begin
    if (rst_n && z_out_valid && z_out_ready) begin
      if (q0.size() == 0) check("np_unexpected_beat", 1, 0);
      else begin
        e0 = q0.pop_front();
        check("np_beat", {z_out_bit, z_out_sof, z_out_last}, e0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
    z_in_valid = 1'b0; z_out_ready = 1'b0; z_in_vec = '0;
    #1;
    check("rst_outs", {out_valid, out_bit, out_sof, out_last, busy}, 5'b0);
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_cnt", frame_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic zero_frames(input int n);
    int caps, k;
    for (int f = 0; f < n; f++) push_frame(7'h00, 1'b0, 1'b1, 1'b0);
    in_vec = 7'h00;
    in_valid = 1'b1;
    caps = 0;
    k = 0;
    while (caps < n && k < n * 10 + 20) begin
      if (in_ready) caps++;
      tick();
      k++;
    end
    in_valid = 1'b0;
    check("zero_caps", caps, n);
    wait_idle(20);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, caps, k;
    bit [3:0] pat;

    // Single frame with parity
    do_reset();
    push_frame(7'b0111001, 1'b0, 1'b1, 1'b0);
    in_vec = 7'b0111001; out_ready = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("first_beat_sof", {out_valid, out_sof, out_bit}, 3'b111);
    wait_idle(20);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_q_empty", q1.size(), 0);

    // Backpressure 1,0,0,1,... with in_vec changed mid-frame
    do_reset();
    push_frame(7'b0111001, 1'b0, 1'b1, 1'b0);
    in_vec = 7'b0111001; out_ready = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_vec = 7'h00;
    pat = 4'b1001;
    k = 0;
    while (busy && k < 60) begin
      out_ready = pat[k % 4];
      tick();
      k++;
    end
    check("bp_idle", busy, 0);
    check("bp_frame_cnt", frame_cnt, 1);
    check("bp_q_empty", q1.size(), 0);

    // Back-to-back frames
    do_reset();
    push_frame(7'h55, 1'b0, 1'b1, 1'b0);
    push_frame(7'h2A, 1'b1, 1'b1, 1'b0);
    out_ready = 1'b1; in_vec = 7'h55; in_valid = 1'b1;
    tick();
    in_vec = 7'h2A;
    caps = 1;
    nv = 0;
    while (out_valid && nv < 40) begin
      if (in_valid && in_ready) caps++;
      nv++;
      tick();
      if (caps == 2) in_valid = 1'b0;
    end
    check("b2b_valid_run", nv, 16);
    check("b2b_caps", caps, 2);
    check("b2b_frame_cnt", frame_cnt, 2);
    check("b2b_q_empty", q1.size(), 0);

    // No-parity instance, all ones
    do_reset();
    push_frame(7'h7F, 1'b0, 1'b0, 1'b1);
    z_in_vec = 7'h7F; z_out_ready = 1'b1; z_in_valid = 1'b1;
    tick();
    z_in_valid = 1'b0;
    k = 0;
    while (z_busy && k < 20) begin
      tick();
      k++;
    end
    check("np_frame_len", k, 7);
    check("np_frame_cnt", z_frame_cnt, 1);
    check("np_q_empty", q0.size(), 0);

    // Reset during beat 4
    do_reset();
    push_frame(7'b0111001, 1'b0, 1'b1, 1'b0);
    in_vec = 7'b0111001; out_ready = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("pre_abort_beat4", {out_valid, out_bit, out_sof}, 3'b110);
    rst_n = 1'b0;
    q1.delete();
    #1;
    check("abort_outs", {out_valid, out_bit, out_sof, out_last, busy}, 5'b0);
    check("abort_frame_cnt", frame_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      check("post_abort_valid", out_valid, 0);
    end
    check("post_abort_frame_cnt", frame_cnt, 0);

    // frame_cnt wrap
    do_reset();
    out_ready = 1'b1;
    zero_frames(255);
    check("cnt_255", frame_cnt, 255);
    zero_frames(1);
    check("cnt_wrap", frame_cnt, 0);
    check("wrap_q_empty", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gate_vector_serializer.md
# gate_vector_serializer

Downstream stage of the 2:1-mux gate bank. It captures the seven-bit gate result vector {nott, xnorr, xorr, norr, orr, nandd, andd} through a valid/ready handshake. It shifts the vector out one bit per accepted beat, LSB first, and can append an even-parity bit. Frames carry start and last markers so a single-wire consumer (a checker, LED driver or UART front end) can reassemble them.

## Interface
Parameters:
- W, 7, captured vector width (bit 0 = andd … bit 6 = nott)
- PARITY_EN, 1, 1 appends an even-parity bit after the data bits; 0 omits it

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  upstream presents in_vec
- in_ready  out  1  block can capture a vector this cycle
- in_vec  in  W  gate result vector
- out_valid  out  1  out_bit is a valid beat
- out_ready  in  1  consumer accepts the current beat
- out_bit  out  1  serial data bit
- out_sof  out  1  high on the first beat of a frame
- out_last  out  1  high on the final beat of a frame (parity beat if PARITY_EN, else data bit W-1)
- busy  out  1  frame in progress (state ≠ IDLE)
- frame_cnt  out  8  completed frames, wraps 255 → 0

## Operation
- FSM states: IDLE, DATA, PAR.
- IDLE: out_valid=0. When in_valid&&in_ready, in_vec goes into shift register sh, bit index idx=0, parity register par=^in_vec, and the state moves to DATA.
- DATA: out_valid=1, out_bit=sh[0], out_sof=(idx==0), out_last=(idx==W-1)&&!PARITY_EN.
  - On out_ready: sh>>=1 and idx++.
  - At idx==W-1: go to PAR if PARITY_EN; otherwise finish the frame.
- PAR: out_valid=1, out_bit=par, out_sof=0, out_last=1. On out_ready the frame finishes.
- Frame finish: frame_cnt++ (mod 256), then the state goes to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This gives back-to-back frames with no bubble: the capture in the finishing cycle loads a new vector and the state goes straight to DATA with idx=0.
- in_vec is ignored outside a capture cycle. Changing it mid-frame has no effect on the frame in flight.
- out_bit, out_sof and out_last hold stable while out_valid && !out_ready.
- out_ready while out_valid=0 has no effect.
- idx width: $clog2(W). There is no wrap; it is cleared on capture.

## Timing
- Reset (async assert, sync release) sets state=IDLE, out_valid=0, out_bit=0, out_sof=0, out_last=0, busy=0, frame_cnt=0, in_ready=1.
- Capture in cycle N puts the first beat (out_valid, out_sof) on the outputs from cycle N+1.
- Beat latency: with out_ready held high, one bit per cycle.
  - Frame length is W+PARITY_EN cycles.
  - With continuous in_valid, throughput is one frame per W+PARITY_EN cycles.
- frame_cnt updates in the cycle after the last beat is accepted.
- Reset asserted mid-frame aborts the frame immediately. No partial count is recorded, and no residual beat appears after release.
- in_ready is combinational from out_ready only in the last-beat case. All other outputs are registered or decoded from registered state.

## Structure
- Package gate_ser_pkg holds:
  - the state enum (IDLE, DATA, PAR)
  - the default width constant GATE_W=7
  - bit-position constants for the gate vector (AND_B=0 … NOT_B=6)
- One sub-module, ser_bit_counter: idx counter with clear, enable, and a terminal flag at W-1. The top holds the FSM, shift register, parity and frame counter.

## Test plan
- Reset, then in_vec=7'b0111001 (s=1,a=0,b=0 gate outputs), out_ready=1. Required beats, LSB first: 1,0,0,1,1,1,0, then parity 0. out_sof on beat 1, out_last on beat 8, frame_cnt=1.
- Backpressure on the same vector: toggle out_ready 1,0,0,1,… Every beat holds stable while stalled, the bit sequence is unchanged, and in_ready stays 0 until the last beat is accepted.
- Back-to-back frames: in_valid held high with vectors 7'h55 then 7'h2A, out_ready=1. There is 16 cycles of continuous out_valid with no gap. Parities are 0 and 1. frame_cnt=2.
- PARITY_EN=0 with in_vec=7'h7F gives 7 beats of 1, with out_last on beat 7.
- Reset mid-frame: assert rst_n=0 after beat 3. All outputs are 0 immediately. After release, out_valid=0 and frame_cnt=0 until the next capture.
- 256 frames of 7'h00 make frame_cnt wrap from 255 to 0. Every parity beat is 0.
